// File: rtl/tf_sched_pkg.sv
// Shared constants, stage tables and state encoding for the twiddle-factor ROM sequencer
// of the 512-point mixed-radix NTT.
package tf_sched_pkg;

    localparam int NUM_STAGES   = 3;
    localparam int BF_PER_STAGE = 64;
    localparam int BASE_W       = 6;
    localparam int SHIFT_W      = 3;

    // Stage s owns ROM words [base, base + 64 >> shift), each reused for 1 << shift slots
    localparam logic [BASE_W-1:0]  STAGE_BASE  [NUM_STAGES] = '{6'd0, 6'd2, 6'd10};
    localparam logic [SHIFT_W-1:0] STAGE_SHIFT [NUM_STAGES] = '{3'd5, 3'd3, 3'd1};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/tf_stage_lut.sv
// Physical stage to (ROM base, slot shift) lookup; kept separate so an alternative
// INTT ROM layout can swap in its own table.
module tf_stage_lut
    import tf_sched_pkg::*;
(
    input  logic [1:0]         ps,
    output logic [BASE_W-1:0]  base,
    output logic [SHIFT_W-1:0] shift
);

    always_comb begin
        base  = '0;
        shift = '0;
        case (ps)
            2'd0: begin
                base  = STAGE_BASE[0];
                shift = STAGE_SHIFT[0];
            end
            2'd1: begin
                base  = STAGE_BASE[1];
                shift = STAGE_SHIFT[1];
            end
            2'd2: begin
                base  = STAGE_BASE[2];
                shift = STAGE_SHIFT[2];
            end
            default: begin
                base  = '0;
                shift = '0;
            end
        endcase
    end

endmodule

// File: rtl/tf_rom_sched.sv
// Twiddle-factor ROM sequencer: walks three radix-8 stages of 64 butterfly slots, issues
// one ROM read per slot and tags each read so Q can be matched to its butterfly.
module tf_rom_sched
    import tf_sched_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int NUM_STAGES = 3,
    parameter int BF_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              stall,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    output logic              tf_valid,
    output logic [1:0]        tf_stage,
    output logic [BF_W-1:0]   tf_bf,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0]      LAST_STAGE = 2'(NUM_STAGES - 1);
    localparam logic [BF_W-1:0] LAST_BF    = BF_W'(BF_PER_STAGE - 1);

    state_t             state;
    state_t             state_next;
    logic [1:0]         stage_cnt;
    logic [BF_W-1:0]    bf_cnt;
    logic               mode_q;
    logic [1:0]         ps;
    logic [BASE_W-1:0]  base;
    logic [SHIFT_W-1:0] shift;
    logic [ADDR_W-1:0]  addr_calc;
    logic [ADDR_W-1:0]  addr_hold;
    logic               last_bf;
    logic               last_stage;

    // INTT walks the same tables in reverse stage order
    assign ps = mode_q ? (LAST_STAGE - stage_cnt) : stage_cnt;

    tf_stage_lut u_lut (
        .ps    (ps),
        .base  (base),
        .shift (shift)
    );

    assign addr_calc  = ADDR_W'(base) + ADDR_W'(bf_cnt >> shift);
    assign last_bf    = (bf_cnt == LAST_BF);
    assign last_stage = (stage_cnt == LAST_STAGE);

    assign rom_en   = (state == RUN) && !stall;
    assign rom_addr = (state == RUN) ? addr_calc : addr_hold;
    assign busy     = (state != IDLE);
    assign done     = (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (rom_en && last_bf && last_stage) state_next = DRAIN;
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The last issued address is kept so rom_addr stays put outside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_cnt <= '0;
            bf_cnt    <= '0;
            mode_q    <= 1'b0;
            addr_hold <= '0;
        end else if (state == IDLE && start) begin
            stage_cnt <= '0;
            bf_cnt    <= '0;
            mode_q    <= mode;
        end else if (rom_en) begin
            addr_hold <= addr_calc;
            if (last_bf) begin
                bf_cnt    <= '0;
                stage_cnt <= last_stage ? 2'd0 : stage_cnt + 2'd1;
            end else begin
                bf_cnt <= bf_cnt + BF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_valid <= 1'b0;
            tf_stage <= '0;
            tf_bf    <= '0;
        end else begin
            tf_valid <= rom_en;
            if (rom_en) begin
                tf_stage <= ps;
                tf_bf    <= bf_cnt;
            end
        end
    end

endmodule

// File: tb/tb_tf_rom_sched.sv
// Directed bench for tf_rom_sched: NTT/INTT runs, stalls, held start, mid-run reset and a
// ROM-model scoreboard on the tagged Q word.
module tb_tf_rom_sched;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic       stall;
    logic [5:0] rom_addr;
    logic       rom_en;
    logic       tf_valid;
    logic [1:0] tf_stage;
    logic [5:0] tf_bf;
    logic       busy;
    logic       done;

    logic [7:0] romMem [64];
    logic [7:0] q;

    int checks   = 0;
    int failures = 0;
    int doneCycle;
    int stallCycles;

    tf_rom_sched #(
        .ADDR_W     (6),
        .NUM_STAGES (3),
        .BF_W       (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .stall    (stall),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .tf_valid (tf_valid),
        .tf_stage (tf_stage),
        .tf_bf    (tf_bf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural twiddle ROM with one cycle of read latency
    always @(posedge clk) begin
        if (rom_en) q <= romMem[rom_addr];
    end

    function automatic logic [7:0] romWord(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Issue n of a run: stage n/64, slot n%64, addresses derived from entry counts 2/8/32
    function automatic int expStage(input bit m, input int n);
        return m ? 2 - n / 64 : n / 64;
    endfunction

    function automatic int expAddr(input bit m, input int n);
        int bf;
        bf = n % 64;
        case (expStage(m, n))
            0:       return bf / 32;
            1:       return 2 + bf / 8;
            default: return 10 + bf / 2;
        endcase
    endfunction

    task automatic applyStimulus(input bit s, input bit m, input bit st);
        start = s;
        mode  = m;
        stall = st;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drives one run from the IDLE cycle T and checks every output each cycle until done
    task automatic runCheck(input bit m, input int stallAt, input int stallLen,
                            input bit randStall, input bit holdStart,
                            output int dCycle, output int sCycles);
        int  issued   = 0;
        int  stallCnt = 0;
        bit  prevEn   = 1'b0;
        int  prevN    = 0;
        bit  finished = 1'b0;
        bit  st;
        dCycle  = -1;
        sCycles = 0;
        @(posedge clk); #1;
        applyStimulus(1'b1, m, 1'b0);
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_rom_en", rom_en, 0);
        for (int c = 1; c <= 400 && !finished; c++) begin
            @(posedge clk); #1;
            st = 1'b0;
            if (issued < 192) begin
                if (randStall) st = ($urandom_range(0, 3) == 0);
                else if (issued == stallAt && stallCnt < stallLen) begin
                    st = 1'b1;
                    stallCnt++;
                end
            end else begin
                st = randStall;
            end
            applyStimulus(holdStart, m, st);
            #1;
            checkOutput("tf_valid", tf_valid, prevEn);
            if (prevEn) begin
                checkOutput("tf_stage", tf_stage, expStage(m, prevN));
                checkOutput("tf_bf", tf_bf, prevN % 64);
                checkOutput("rom_q", q, romWord(expAddr(m, prevN)));
            end
            if (issued < 192) begin
                checkOutput("busy_run", busy, 1);
                checkOutput("done_run", done, 0);
                checkOutput("rom_en", rom_en, !st);
                checkOutput("rom_addr", rom_addr, expAddr(m, issued));
                prevEn = !st;
                if (!st) begin
                    prevN = issued;
                    issued++;
                end else begin
                    sCycles++;
                end
            end else begin
                checkOutput("busy_drain", busy, 1);
                checkOutput("done_drain", done, 1);
                checkOutput("rom_en_drain", rom_en, 0);
                prevEn   = 1'b0;
                dCycle   = c;
                finished = 1'b1;
            end
        end
        if (!finished) checkOutput("run_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) romMem[i] = (i < 42) ? romWord(i) : 8'hxx;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_rom_en", rom_en, 0);
        checkOutput("rst_tf_valid", tf_valid, 0);
        checkOutput("rst_tf_stage", tf_stage, 0);
        checkOutput("rst_tf_bf", tf_bf, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] NTT run, no stall");
        runCheck(1'b0, -1, 0, 1'b0, 1'b0, doneCycle, stallCycles);
        checkOutput("ntt_done_cycle", doneCycle, 193);
        @(posedge clk); #2;
        checkOutput("ntt_after_busy", busy, 0);
        checkOutput("ntt_after_done", done, 0);
        checkOutput("ntt_after_valid", tf_valid, 0);
        checkOutput("ntt_hold_addr", rom_addr, 41);

        $display("[TB] INTT run, no stall");
        runCheck(1'b1, -1, 0, 1'b0, 1'b0, doneCycle, stallCycles);
        checkOutput("intt_done_cycle", doneCycle, 193);
        @(posedge clk); #2;
        checkOutput("intt_after_busy", busy, 0);
        checkOutput("intt_hold_addr", rom_addr, 1);

        $display("[TB] NTT run, 3-cycle stall at stage 0 slot 31");
        runCheck(1'b0, 31, 3, 1'b0, 1'b0, doneCycle, stallCycles);
        checkOutput("stall_cycles", stallCycles, 3);
        checkOutput("stall_done_cycle", doneCycle, 196);

        $display("[TB] start held high, back-to-back runs");
        runCheck(1'b0, -1, 0, 1'b0, 1'b1, doneCycle, stallCycles);
        checkOutput("b2b_first_done", doneCycle, 193);
        runCheck(1'b0, -1, 0, 1'b0, 1'b1, doneCycle, stallCycles);
        checkOutput("b2b_second_done", doneCycle, 193);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        checkOutput("b2b_idle_busy", busy, 0);
        checkOutput("b2b_idle_en", rom_en, 0);

        $display("[TB] reset asserted at stage 1 slot 10");
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (74) @(posedge clk);
        #2;
        checkOutput("pre_rst_addr", rom_addr, 3);
        checkOutput("pre_rst_en", rom_en, 1);
        checkOutput("pre_rst_tf_bf", tf_bf, 9);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_addr", rom_addr, 0);
        checkOutput("mid_rst_en", rom_en, 0);
        checkOutput("mid_rst_valid", tf_valid, 0);
        checkOutput("mid_rst_stage", tf_stage, 0);
        checkOutput("mid_rst_bf", tf_bf, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        runCheck(1'b0, -1, 0, 1'b0, 1'b0, doneCycle, stallCycles);
        checkOutput("post_rst_done_cycle", doneCycle, 193);

        $display("[TB] INTT run with random stall");
        runCheck(1'b1, -1, 0, 1'b1, 1'b0, doneCycle, stallCycles);
        checkOutput("rand_done_cycle", doneCycle, 193 + stallCycles);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
